// File: rtl/hachure_gpio_if.sv
// Wishbone classic slave bus bundle for the hachure_gpio register block.
// Signal names follow the slave's point of view (_i into the block, _o out of it).
`timescale 1ns/1ps
interface hachure_gpio_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/hachure_gpio.sv
// GPIO block with pad control registers, 2-flop input synchroniser and
// per-bit edge interrupts, behind a single-cycle-ack Wishbone classic slave.
`timescale 1ns/1ps
module hachure_gpio #(
    parameter int NUM_GPIO = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    hachure_gpio_if.slave       wb,
    input  logic [NUM_GPIO-1:0] gpi_i,
    output logic [NUM_GPIO-1:0] gpo_o,
    output logic [NUM_GPIO-1:0] gpeo_o,
    output logic [NUM_GPIO-1:0] gpcs_o,
    output logic [NUM_GPIO-1:0] gpsl_o,
    output logic [NUM_GPIO-1:0] gppu_o,
    output logic [NUM_GPIO-1:0] gppd_o,
    output logic                irq_o
);

    typedef logic [NUM_GPIO-1:0] gpio_t;

    localparam gpio_t      GPIO_ZERO = {NUM_GPIO{1'b0}};
    localparam logic [3:0] ADR_GPO   = 4'd0;
    localparam logic [3:0] ADR_GPEO  = 4'd1;
    localparam logic [3:0] ADR_GPCS  = 4'd2;
    localparam logic [3:0] ADR_GPSL  = 4'd3;
    localparam logic [3:0] ADR_GPPU  = 4'd4;
    localparam logic [3:0] ADR_GPPD  = 4'd5;
    localparam logic [3:0] ADR_GPI   = 4'd6;
    localparam logic [3:0] ADR_IEN   = 4'd7;
    localparam logic [3:0] ADR_IEDG  = 4'd8;
    localparam logic [3:0] ADR_IPND  = 4'd9;

    function automatic logic [31:0] zext(input gpio_t v);
        zext = {{(32-NUM_GPIO){1'b0}}, v};
    endfunction

    gpio_t       r_gpo, r_gpeo, r_gpcs, r_gpsl, r_gppu, r_gppd;
    gpio_t       r_irq_en, r_irq_edge, r_irq_pend;
    gpio_t       r_sync1, r_sync2, r_prev;
    logic [1:0]  r_arm_cnt;
    logic        r_ack;
    logic [31:0] r_dat;

    logic        w_req;
    logic        w_wr;
    logic        w_armed;
    gpio_t       w_wdata;
    gpio_t       w_rise, w_fall, w_evt, w_w1c;
    logic [31:0] w_rdata;
    logic        w_unused;

    // A new transfer starts only when the previous ack has been retired.
    assign w_req   = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_wr    = w_req & wb.wb_we_i & wb.wb_sel_i[0];
    assign w_wdata = wb.wb_dat_i[NUM_GPIO-1:0];
    assign w_armed = (r_arm_cnt == 2'd3);
    assign w_rise  = r_sync2 & ~r_prev;
    assign w_fall  = ~r_sync2 & r_prev;
    assign w_unused = &{1'b0, wb.wb_sel_i[3:1], wb.wb_dat_i[31:NUM_GPIO]};

    // Read data mux over the register map.
    always_comb begin
        w_rdata = 32'd0;
        case (wb.wb_adr_i)
            ADR_GPO:  w_rdata = zext(r_gpo);
            ADR_GPEO: w_rdata = zext(r_gpeo);
            ADR_GPCS: w_rdata = zext(r_gpcs);
            ADR_GPSL: w_rdata = zext(r_gpsl);
            ADR_GPPU: w_rdata = zext(r_gppu);
            ADR_GPPD: w_rdata = zext(r_gppd);
            ADR_GPI:  w_rdata = zext(r_sync2);
            ADR_IEN:  w_rdata = zext(r_irq_en);
            ADR_IEDG: w_rdata = zext(r_irq_edge);
            ADR_IPND: w_rdata = zext(r_irq_pend);
            default:  w_rdata = 32'd0;
        endcase
    end

    // Edge events, selected per bit by IRQ_EDGE, suppressed until armed.
    always_comb begin
        w_evt = GPIO_ZERO;
        if (w_armed) begin
            w_evt = (w_rise & r_irq_edge) | (w_fall & ~r_irq_edge);
        end else begin
            w_evt = GPIO_ZERO;
        end
    end

    // Write-one-to-clear mask for the pending register.
    always_comb begin
        w_w1c = GPIO_ZERO;
        if (w_wr && (wb.wb_adr_i == ADR_IPND)) begin
            w_w1c = w_wdata;
        end else begin
            w_w1c = GPIO_ZERO;
        end
    end

    // Input synchroniser, previous-value stage and post-reset arming counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1   <= GPIO_ZERO;
            r_sync2   <= GPIO_ZERO;
            r_prev    <= GPIO_ZERO;
            r_arm_cnt <= 2'd0;
        end else begin
            r_sync1 <= gpi_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end else begin
                r_arm_cnt <= r_arm_cnt;
            end
        end
    end

    // Bus handshake: ack one cycle after request, read data captured with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_req;
            if (w_req && !wb.wb_we_i) begin
                r_dat <= w_rdata;
            end else begin
                r_dat <= 32'd0;
            end
        end
    end

    // Control register writes land on the edge that raises the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gpo      <= GPIO_ZERO;
            r_gpeo     <= GPIO_ZERO;
            r_gpcs     <= GPIO_ZERO;
            r_gpsl     <= GPIO_ZERO;
            r_gppu     <= GPIO_ZERO;
            r_gppd     <= GPIO_ZERO;
            r_irq_en   <= GPIO_ZERO;
            r_irq_edge <= GPIO_ZERO;
        end else if (w_wr) begin
            case (wb.wb_adr_i)
                ADR_GPO:  r_gpo      <= w_wdata;
                ADR_GPEO: r_gpeo     <= w_wdata;
                ADR_GPCS: r_gpcs     <= w_wdata;
                ADR_GPSL: r_gpsl     <= w_wdata;
                ADR_GPPU: r_gppu     <= w_wdata;
                ADR_GPPD: r_gppd     <= w_wdata;
                ADR_IEN:  r_irq_en   <= w_wdata;
                ADR_IEDG: r_irq_edge <= w_wdata;
                default:  r_gpo      <= r_gpo;
            endcase
        end else begin
            r_gpo <= r_gpo;
        end
    end

    // Pending bits: an event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_pend <= GPIO_ZERO;
        end else begin
            r_irq_pend <= (r_irq_pend & ~w_w1c) | w_evt;
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign gpo_o       = r_gpo;
    assign gpeo_o      = r_gpeo;
    assign gpcs_o      = r_gpcs;
    assign gpsl_o      = r_gpsl;
    assign gppu_o      = r_gppu;
    assign gppd_o      = r_gppd & ~r_gppu;
    assign irq_o       = |(r_irq_pend & r_irq_en);

endmodule

// File: tb/tb_hachure_gpio.sv
// Self-checking bench for hachure_gpio: register table, directed corner
// sequences and randomized traffic against a cycle-level sample-history model.
`timescale 1ns/1ps
module tb_hachure_gpio;

    logic       clk;
    logic       rst;
    logic [3:0] gpi;
    logic [3:0] gpo, gpeo, gpcs, gpsl, gppu, gppd;
    logic       irq;

    int total = 0;
    int bad   = 0;

    hachure_gpio_if bus_if ();

    hachure_gpio #(.NUM_GPIO(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus_if),
        .gpi_i (gpi),
        .gpo_o (gpo),
        .gpeo_o(gpeo),
        .gpcs_o(gpcs),
        .gpsl_o(gpsl),
        .gppu_o(gppu),
        .gppd_o(gppd),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: registers as an array, pad history as the last three
    // clock samples; pending bits follow the event rules directly.
    logic [3:0]  m_reg [0:15];
    logic [3:0]  h0, h1, h2;
    int          since;
    logic        m_ack;
    logic [31:0] m_dat;

    always @(posedge clk) begin
        logic       req;
        logic [3:0] evt;
        logic [3:0] w1c;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 4'd0;
            h0 = 4'd0; h1 = 4'd0; h2 = 4'd0;
            since = 0; m_ack = 1'b0; m_dat = 32'd0;
        end else begin
            req = bus_if.wb_cyc_i && bus_if.wb_stb_i && !m_ack;
            evt = 4'd0;
            if (since >= 3) evt = (h1 & ~h2 & m_reg[8]) | (~h1 & h2 & ~m_reg[8]);
            m_dat = 32'd0;
            if (req && !bus_if.wb_we_i) begin
                if (bus_if.wb_adr_i == 4'd6) m_dat = {28'd0, h1};
                else if (bus_if.wb_adr_i <= 4'd9) m_dat = {28'd0, m_reg[bus_if.wb_adr_i]};
                else m_dat = 32'd0;
            end
            w1c = 4'd0;
            if (req && bus_if.wb_we_i && bus_if.wb_sel_i[0]) begin
                if (bus_if.wb_adr_i == 4'd9) w1c = bus_if.wb_dat_i[3:0];
                else if (bus_if.wb_adr_i <= 4'd8 && bus_if.wb_adr_i != 4'd6)
                    m_reg[bus_if.wb_adr_i] = bus_if.wb_dat_i[3:0];
            end
            m_reg[9] = (m_reg[9] & ~w1c) | evt;
            m_ack = req;
            h2 = h1; h1 = h0; h0 = gpi;
            if (since < 3) since++;
        end
        #2;
        check("m_ack",  32'(bus_if.wb_ack_o), 32'(m_ack));
        check("m_dat",  bus_if.wb_dat_o, m_dat);
        check("m_gpo",  32'(gpo),  32'(m_reg[0]));
        check("m_gpeo", 32'(gpeo), 32'(m_reg[1]));
        check("m_gpcs", 32'(gpcs), 32'(m_reg[2]));
        check("m_gpsl", 32'(gpsl), 32'(m_reg[3]));
        check("m_gppu", 32'(gppu), 32'(m_reg[4]));
        check("m_gppd", 32'(gppd), 32'(m_reg[5] & ~m_reg[4]));
        check("m_irq",  32'(irq),  32'(|(m_reg[9] & m_reg[7])));
    end

    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat);
        bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = w;
        bus_if.wb_adr_i = a; bus_if.wb_dat_i = d; bus_if.wb_sel_i = s;
        lat = 0; rd = 32'd0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (bus_if.wb_ack_o) begin
                lat = i; rd = bus_if.wb_dat_o;
                break;
            end
        end
        bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus(1'b1, a, d, 4'h1, rd, lat);
        check("wr_lat", 32'(lat), 32'd1);
    endtask

    task automatic rdc(input string nm, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(1'b0, a, 32'd0, 4'h1, rd, lat);
        check("rd_lat", 32'(lat), 32'd1);
        check(nm, rd, exp);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] rd;
        int lat;
        tbl[0]  = '{1'b1, 4'd4,  32'h0000_0003, 4'h1, 32'h0};
        tbl[1]  = '{1'b1, 4'd5,  32'h0000_0006, 4'h1, 32'h0};
        tbl[2]  = '{1'b0, 4'd5,  32'h0,         4'h1, 32'h6};
        tbl[3]  = '{1'b0, 4'd4,  32'h0,         4'h1, 32'h3};
        tbl[4]  = '{1'b1, 4'd0,  32'h0000_005A, 4'h1, 32'h0};
        tbl[5]  = '{1'b0, 4'd0,  32'h0,         4'h1, 32'hA};
        tbl[6]  = '{1'b1, 4'd2,  32'h0000_000F, 4'hE, 32'h0};
        tbl[7]  = '{1'b0, 4'd2,  32'h0,         4'h1, 32'h0};
        tbl[8]  = '{1'b1, 4'd2,  32'h0000_0009, 4'h1, 32'h0};
        tbl[9]  = '{1'b0, 4'd2,  32'h0,         4'h1, 32'h9};
        tbl[10] = '{1'b1, 4'd12, 32'h0000_00FF, 4'h1, 32'h0};
        tbl[11] = '{1'b0, 4'd12, 32'h0,         4'h1, 32'h0};
        tbl[12] = '{1'b1, 4'd6,  32'h0000_000F, 4'h1, 32'h0};
        tbl[13] = '{1'b0, 4'd6,  32'h0,         4'h1, 32'h0};
        tbl[14] = '{1'b1, 4'd3,  32'hFFFF_FFF3, 4'h1, 32'h0};
        tbl[15] = '{1'b0, 4'd3,  32'h0,         4'h1, 32'h3};
        tbl[16] = '{1'b0, 4'd15, 32'h0,         4'h0, 32'h0};

        bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
        bus_if.wb_adr_i = 4'd0; bus_if.wb_dat_i = 32'd0; bus_if.wb_sel_i = 4'd0;
        rst = 1'b1; gpi = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus_if.wb_ack_o), 32'd0);
        check("rst_pads", 32'({gpo, gpeo, gpcs, gpsl, gppu, gppd}), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Output enable write, visible from the ack edge, then readback.
        bus(1'b1, 4'd1, 32'h0000_000F, 4'h1, rd, lat);
        check("gpeo_wr_lat", 32'(lat), 32'd1);
        check("gpeo_pad", 32'(gpeo), 32'hF);
        rdc("gpeo_rd", 4'd1, 32'h0000_000F);

        for (int i = 0; i < 17; i++) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, lat);
            check("tbl_lat", 32'(lat), 32'd1);
            if (!tbl[i].we) check("tbl_rd", rd, tbl[i].exp);
        end
        check("gppu_pad", 32'(gppu), 32'h3);
        check("gppd_pad", 32'(gppd), 32'h4);

        // Rising edge on bit 0: pending three edges after the sampling edge.
        wr(4'd8, 32'h1);
        wr(4'd7, 32'h1);
        gpi[0] = 1'b1;
        @(negedge clk); check("irq_e0", 32'(irq), 32'd0);
        @(negedge clk); check("irq_e1", 32'(irq), 32'd0);
        @(negedge clk); check("irq_e2", 32'(irq), 32'd1);
        rdc("pend_b0", 4'd9, 32'h1);
        rdc("gpi_b0", 4'd6, 32'h1);
        wr(4'd9, 32'h1);
        check("irq_clr", 32'(irq), 32'd0);

        // Event on bit 1 lands on the same edge as its W1C: set wins.
        wr(4'd8, 32'h3);
        gpi[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wr(4'd9, 32'h2);
        rdc("pend_setwins", 4'd9, 32'h2);
        wr(4'd9, 32'h2);
        rdc("pend_w1c", 4'd9, 32'h0);

        // Aborted strobes: neither cyc-only nor stb-only cycles are acked.
        bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b1;
        bus_if.wb_adr_i = 4'd0; bus_if.wb_dat_i = 32'hF; bus_if.wb_sel_i = 4'h1;
        @(negedge clk); check("abort_cyc", 32'(bus_if.wb_ack_o), 32'd0);
        bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b1;
        @(negedge clk); check("abort_stb", 32'(bus_if.wb_ack_o), 32'd0);
        bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
        rdc("abort_gpo", 4'd0, 32'hA);

        // Reset during a write; pads held high through the release.
        gpi = 4'hF; rst = 1'b1;
        bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = 1'b1;
        bus_if.wb_adr_i = 4'd0; bus_if.wb_dat_i = 32'hF;
        @(negedge clk);
        check("rstwr_ack", 32'(bus_if.wb_ack_o), 32'd0);
        check("rstwr_gpo", 32'(gpo), 32'd0);
        bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rdc("pend_quiet", 4'd9, 32'h0);
        gpi = 4'hB;
        repeat (5) @(negedge clk);
        rdc("pend_fall2", 4'd9, 32'h4);
        rdc("gpi_b", 4'd6, 32'hB);

        // Randomized traffic, checked every cycle by the model.
        for (int it = 0; it < 500; it++) begin
            int op;
            logic [3:0] a;
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) gpi = 4'($urandom);
            a = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(7, 9)) : 4'($urandom_range(0, 15));
            if (op <= 5) begin
                bus(1'($urandom), a, $urandom, 4'($urandom), rd, lat);
            end else if (op == 6) begin
                @(negedge clk);
            end else if (op == 7) begin
                bus_if.wb_cyc_i = 1'b1; bus_if.wb_we_i = 1'b1; bus_if.wb_adr_i = a;
                bus_if.wb_dat_i = $urandom; bus_if.wb_sel_i = 4'hF;
                @(negedge clk);
                bus_if.wb_cyc_i = 1'b0; bus_if.wb_we_i = 1'b0;
            end else if (op == 8 && (it % 16) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = 1'b1; bus_if.wb_adr_i = a;
                @(negedge clk);
                bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
            end
        end
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hachure_gpio.md
HACHURE_GPIO -- requirements
Module: hachure_gpio

Interface
REQ-001 Parameter NUM_GPIO, default 4, number of GPIO lines; legal range 1..8.
REQ-002 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 wb_cyc_i  input  1  Wishbone classic bus cycle.
REQ-005 wb_stb_i  input  1  Wishbone strobe.
REQ-006 wb_we_i  input  1  write enable.
REQ-007 wb_adr_i  input  4  word address, register index.
REQ-008 wb_dat_i  input  32  write data.
REQ-009 wb_sel_i  input  4  byte select; only bit 0 is used.
REQ-010 wb_dat_o  output  32  read data.
REQ-011 wb_ack_o  output  1  transfer acknowledge.
REQ-012 gpi_i  input  NUM_GPIO  raw pad input values, asynchronous to clk_i.
REQ-013 gpo_o, gpeo_o, gpcs_o, gpsl_o, gppu_o, gppd_o  output  NUM_GPIO each  pad control:
- gpo_o: output value.
- gpeo_o: output enable.
- gpcs_o: input type, 1 = Schmitt.
- gpsl_o: slew, 1 = slow.
- gppu_o / gppd_o: pull-up / pull-down.
REQ-014 irq_o  output  1  level interrupt request.

Function
REQ-015 Register map by wb_adr_i:
- RW: 0 GPO, 1 GPEO, 2 GPCS, 3 GPSL, 4 GPPU, 5 GPPD, 7 IRQ_EN, 8 IRQ_EDGE (1 = rising, 0 = falling).
- RO: 6 GPI, returns the synchronised inputs.
- W1C: 9 IRQ_PEND.
REQ-016 Each register occupies bits [NUM_GPIO-1:0]; all other read bits are 0.
REQ-017 Reads of addresses 10..15 return 0; writes to 10..15, to GPI, and with wb_sel_i[0]=0 change no state; all of these are still acknowledged.
REQ-018 wb_ack_o asserts exactly one cycle after a cycle with wb_cyc_i & wb_stb_i & ~wb_ack_o, and stays high for one cycle.
REQ-019 A held strobe therefore yields an ack every second cycle.
REQ-020 A write updates its register on the same clock edge that raises wb_ack_o.
REQ-021 wb_dat_o carries read data only while wb_ack_o=1 and a read is in progress; otherwise wb_dat_o is 0.
REQ-022 Dropping wb_cyc_i or wb_stb_i before ack aborts the transfer: no ack is issued and no register changes.
REQ-023 gpi_i passes through a 2-flop synchroniser (sync2); the GPI register value equals sync2.
REQ-024 A pad change becomes readable via GPI 2 cycles after it is sampled.
REQ-025 Edge detector keeps prev = sync2 delayed by one cycle.
- Rising event: sync2 & ~prev.
- Falling event: ~sync2 & prev.
- Event polarity per bit is selected by IRQ_EDGE.
REQ-026 An event sets its IRQ_PEND bit whether or not IRQ_EN is set; the pending bit is set 3 cycles after the pad transition is sampled.
REQ-027 Writing 1 to an IRQ_PEND bit clears it; writing 0 has no effect.
REQ-028 If an event and a W1C hit the same bit in the same cycle, the set wins and the bit stays 1.
REQ-029 irq_o = |(IRQ_PEND & IRQ_EN), driven combinationally from registered state.
REQ-030 Changing IRQ_EDGE while an input is held does not by itself create an event; only sync2/prev differences create events.
REQ-031 gpo_o, gpeo_o, gpcs_o and gpsl_o mirror their registers directly.
REQ-032 gppu_o = GPPU.
REQ-033 gppd_o = GPPD & ~GPPU, so pull-up wins and both pulls are never driven on one pin.

Reset
REQ-034 When rst_i=1 at a clock edge, all registers, synchroniser flops, prev and wb_ack_o clear to 0, so every output is 0 and all pads become inputs.
REQ-035 A bus access in flight when reset asserts is dropped: no ack, no write.
REQ-036 The edge detector is disarmed while rst_i=1 and during the first 3 cycles after rst_i deasserts; no IRQ_PEND bit can be set in that window.
REQ-037 An input already high at reset release therefore produces no rising event.
REQ-038 Reset must be held for at least 1 cycle.

Verification
REQ-039 Write 0xF to GPEO, then read GPEO -> each ack is exactly 1 cycle after strobe; read returns 0x0000000F; gpeo_o=4'hF from the write-ack edge onward.
REQ-040 GPPU=0x3 and GPPD=0x6 -> gppu_o=4'h3 and gppd_o=4'h4; a GPPD readback returns 0x6.
REQ-041 IRQ_EDGE=0x1, IRQ_EN=0x1; drive gpi_i[0] 0->1 -> IRQ_PEND[0]=1 and irq_o=1 three cycles after sampling; a GPI read returns bit0=1. Write 0x1 to IRQ_PEND -> irq_o=0.
REQ-042 Hold gpi_i=4'hF through reset and release -> IRQ_PEND stays 0 for 10 cycles; then drive gpi_i[2] to 0 with IRQ_EDGE[2]=0 -> IRQ_PEND=0x4.
REQ-043 Force a rising event on bit 1 in the same cycle as a W1C of 0x2 -> IRQ_PEND[1] remains 1.
REQ-044 Access to address 12 and an aborted strobe -> address 12 returns 0 and is acked; the aborted strobe gives no ack and no state change; rst_i mid-write leaves the target register at 0.
